toggle_cover_collector: RTL and testbench

Synthesizable sink for toggle-coverage events. Each reporting point drives a valid vector plus the base cover index of its lane 0. This block buffers those event groups, records every hit into a bitmap of COVER_TOTAL bits, and keeps a count of distinct points covered. A word-serial dump port and a clear command let an on-chip debug or host path read the coverage without DPI.

---
 rtl/toggle_cover_collector.sv | 206 ++++++++++++++++++++
 tb/tb_toggle_cover_collector.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage sink: buffers event groups, drains one hit per cycle into a
// coverage bitmap with a distinct-hit counter, and offers word-serial dump/clear.
module toggle_cover_collector #(
  parameter  int COVER_TOTAL = 10906,
  parameter  int LANES       = 5,
  parameter  int WORD_W      = 32,
  parameter  int FIFO_DEPTH  = 4,
  localparam int NUM_WORDS   = (COVER_TOTAL + WORD_W - 1) / WORD_W,
  localparam int IDX_W       = $clog2(COVER_TOTAL),
  localparam int AW          = $clog2(NUM_WORDS),
  localparam int CW          = $clog2(COVER_TOTAL + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LANES-1:0]  in_valid,
  input  logic [IDX_W-1:0]  in_base,
  output logic              in_ready,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]     dump_addr,
  output logic [WORD_W-1:0] dump_word,
  output logic              dump_last,
  input  logic              clear_req,
  output logic              busy,
  output logic [CW-1:0]     covered_count,
  output logic              oor_seen
);
  localparam int BW = $clog2(WORD_W);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DUMP, CLEAR} state_t;
  typedef struct packed {
    logic [LANES-1:0] vld;
    logic [IDX_W-1:0] base;
  } grp_t;

  state_t state_q, state_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0] bitmap;
  logic [AW-1:0] clr_addr;

  // ---------------- input FIFO ----------------
  grp_t          fifo [FIFO_DEPTH];
  logic [PW:0]   wp, rp;
  logic          full, empty, push;

  assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty    = (wp == rp);
  assign in_ready = !full && (state_q != CLEAR);
  assign push     = in_ready && (|in_valid);

  always_ff @(posedge clock) begin
    if (push) fifo[wp[PW-1:0]] <= '{vld: in_valid, base: in_base};
  end

  // ---------------- drain: one set lane per cycle ----------------
  grp_t             head;
  logic [LANES-1:0] done_q, rem, sel_oh, rem_nxt;
  logic [LW-1:0]    sel_k;
  logic             drain;
  logic [IDX_W:0]   lane_idx;

  assign head     = fifo[rp[PW-1:0]];
  assign rem      = head.vld & ~done_q;
  assign drain    = !empty && (state_q != CLEAR);
  assign sel_oh   = LANES'(1) << sel_k;
  assign rem_nxt  = rem & ~sel_oh;
  assign lane_idx = {1'b0, head.base} + (IDX_W+1)'(sel_k);

  always_comb begin
    sel_k = '0;
    for (int k = LANES-1; k >= 0; k--)
      if (rem[k]) sel_k = LW'(k);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp     <= '0;
      rp     <= '0;
      done_q <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (drain) begin
        if (rem_nxt == '0) begin
          rp     <= rp + 1'b1;
          done_q <= '0;
        end else begin
          done_q <= done_q | sel_oh;
        end
      end
    end
  end

  // ---------------- bitmap write stage ----------------
  // Held (not retired) while clearing so a hit drained just before CLEAR lands after it.
  logic           st_vld;
  logic [IDX_W:0] st_idx;
  logic           wr_en, st_oor, wr_set;
  logic [AW-1:0]  wr_word;
  logic [BW-1:0]  wr_bit;

  assign wr_en   = st_vld && (state_q != CLEAR);
  assign st_oor  = st_idx >= (IDX_W+1)'(COVER_TOTAL);
  assign wr_set  = wr_en && !st_oor;
  assign wr_word = AW'(st_idx >> BW);
  assign wr_bit  = st_idx[BW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_vld <= 1'b0;
      st_idx <= '0;
    end else if (drain) begin
      st_vld <= 1'b1;
      st_idx <= lane_idx;
    end else if (wr_en) begin
      st_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitmap <= '0;
    end else if (state_q == CLEAR) begin
      bitmap[clr_addr] <= '0;
    end else if (wr_set) begin
      bitmap[wr_word][wr_bit] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      covered_count <= '0;
      oor_seen      <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == CLEAR)
        covered_count <= '0;
      else if (wr_set && !bitmap[wr_word][wr_bit])
        covered_count <= covered_count + 1'b1;
      if (wr_en && st_oor) oor_seen <= 1'b1;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
               else if (dump_req) state_d = DUMP;
      DUMP:    if (dump_valid && dump_ready && dump_last) state_d = IDLE;
      CLEAR:   if (clr_addr == AW'(NUM_WORDS-1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                clr_addr <= '0;
    else if (state_q == IDLE && state_d == CLEAR) clr_addr <= '0;
    else if (state_q == CLEAR)                clr_addr <= clr_addr + 1'b1;
  end

  // ---------------- dump port ----------------
  // The loaded word includes a hit retiring on the same edge, so it matches
  // the bitmap during the cycle the word is first shown.
  logic [AW-1:0]     nxt_addr;
  logic [WORD_W-1:0] nxt_word;

  always_comb begin
    nxt_addr = (state_q == IDLE) ? '0 : dump_addr + 1'b1;
    nxt_word = bitmap[nxt_addr];
    if (wr_set && wr_word == nxt_addr) nxt_word[wr_bit] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_word  <= '0;
      dump_last  <= 1'b0;
    end else if (state_q == IDLE && state_d == DUMP) begin
      dump_valid <= 1'b1;
      dump_addr  <= '0;
      dump_word  <= nxt_word;
      dump_last  <= (NUM_WORDS == 1);
    end else if (state_q == DUMP && dump_valid && dump_ready) begin
      if (dump_last) begin
        dump_valid <= 1'b0;
        dump_addr  <= '0;
        dump_word  <= '0;
        dump_last  <= 1'b0;
      end else begin
        dump_addr  <= nxt_addr;
        dump_word  <= nxt_word;
        dump_last  <= (nxt_addr == AW'(NUM_WORDS-1));
      end
    end
  end

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Scoreboard bench for toggle_cover_collector: a bit-level coverage model queues
// expected dump words; every DUT dump word is popped and compared.
module tb_toggle_cover_collector;
  localparam int CT = 10906;
  localparam int NW = 341;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  in_valid;
  logic [13:0] in_base;
  logic        in_ready;
  logic        dump_req, dump_valid, dump_ready, dump_last;
  logic [8:0]  dump_addr;
  logic [31:0] dump_word;
  logic        clear_req, busy, oor_seen;
  logic [13:0] covered_count;

  toggle_cover_collector dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_base(in_base), .in_ready(in_ready),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_word(dump_word), .dump_last(dump_last),
    .clear_req(clear_req), .busy(busy),
    .covered_count(covered_count), .oor_seen(oor_seen)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] w;
    logic        l;
  } exp_t;

  exp_t q[$];
  bit   mdl [NW*32];
  int   mdl_cnt;
  bit   mdl_oor;
  int   checks, failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NW*32; i++) mdl[i] = 1'b0;
    mdl_cnt = 0;
  endtask

  function automatic logic [31:0] mword(input int w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = (w*32+b < CT) ? mdl[w*32+b] : 1'b0;
    return r;
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [4:0] v, input int base);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clock); n++; end
    chk("send_ready", in_ready, 1);
    in_valid = v;
    in_base  = 14'(base);
    for (int k = 0; k < 5; k++) begin
      if (v[k]) begin
        if (base + k < CT) begin
          if (!mdl[base+k]) begin mdl[base+k] = 1'b1; mdl_cnt++; end
        end else mdl_oor = 1'b1;
      end
    end
    @(negedge clock);
    in_valid = '0;
  endtask

  task automatic run_dump(input bit toggle);
    logic [3:0]  pat = 4'b1001;
    logic [8:0]  pa;
    logic [31:0] pw;
    bit          stalled = 0, done = 0, rdy;
    int          cyc = 0;
    exp_t        e;
    q.delete();
    for (int w = 0; w < NW; w++) q.push_back('{a: 9'(w), w: mword(w), l: (w == NW-1)});
    dump_req = 1'b1;
    @(negedge clock);
    dump_req = 1'b0;
    chk("dump_start_valid", dump_valid, 1);
    chk("dump_start_addr", dump_addr, 0);
    chk("dump_start_busy", busy, 1);
    while (!done && cyc < 3000) begin
      if (stalled) begin
        chk("dump_hold_addr", dump_addr, pa);
        chk("dump_hold_word", dump_word, pw);
      end
      rdy = toggle ? pat[cyc%4] : 1'b1;
      dump_ready = rdy;
      if (dump_valid && rdy) begin
        chk("dump_q_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("dump_addr", dump_addr, e.a);
          chk("dump_word", dump_word, e.w);
          chk("dump_last", dump_last, e.l);
          if (e.l) done = 1;
        end
        stalled = 0;
      end else begin
        stalled = dump_valid;
        pa = dump_addr;
        pw = dump_word;
      end
      @(negedge clock);
      cyc++;
    end
    dump_ready = 1'b0;
    chk("dump_done", done, 1);
    chk("dump_q_left", q.size(), 0);
    chk("dump_end_busy", busy, 0);
    chk("dump_end_valid", dump_valid, 0);
  endtask

  task automatic do_clear(input bit with_dump);
    int n = 0;
    clear_req = 1'b1;
    dump_req  = with_dump;
    @(negedge clock);
    clear_req = 1'b0;
    dump_req  = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_count", covered_count, 0);
    chk("clr_no_dump", dump_valid, 0);
    chk("clr_in_ready", in_ready, 0);
    while (busy && n < 1000) begin n++; @(negedge clock); end
    chk("clr_busy_cycles", n, NW);
    mdl_clear();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_dump_valid"}, dump_valid, 0);
    chk({tag, "_dump_addr"}, dump_addr, 0);
    chk({tag, "_dump_word"}, dump_word, 0);
    chk({tag, "_dump_last"}, dump_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, covered_count, 0);
    chk({tag, "_oor"}, oor_seen, 0);
  endtask

  initial begin
    checks = 0; failures = 0; mdl_oor = 0;
    mdl_clear();
    reset = 1'b1; in_valid = '0; in_base = '0;
    dump_req = 0; dump_ready = 0; clear_req = 0;
    #12;
    chk_reset_vals("rst");
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // single hit with latency
    send(5'b00001, 100);
    chk("lat_t1", covered_count, 0);
    @(negedge clock);
    chk("lat_t1b", covered_count, 0);
    @(negedge clock);
    chk("lat_t2", covered_count, 1);
    idle(5);
    run_dump(1'b0);

    // clear beats simultaneous dump, then bitmap dumps as zeros
    do_clear(1'b1);
    chk("clr_count_after", covered_count, 0);
    run_dump(1'b1);

    // multi-lane with duplicate group
    send(5'b11111, 10);
    idle(10);
    chk("dup_first", covered_count, 5);
    send(5'b11111, 10);
    idle(10);
    chk("dup_second", covered_count, 5);
    chk("dup_oor", oor_seen, 0);
    run_dump(1'b1);

    // out of range at the top of the index space
    do_clear(1'b0);
    send(5'b11111, 10904);
    idle(10);
    chk("oor_count", covered_count, mdl_cnt);
    chk("oor_flag", oor_seen, mdl_oor);
    run_dump(1'b0);
    do_clear(1'b0);
    chk("oor_sticky", oor_seen, 1);

    // back-to-back groups fill the FIFO
    for (int g = 0; g < 6; g++) begin
      if (g == 4) chk("bp_full", in_ready, 0);
      send(5'b11111, 2000 + 5*g);
    end
    idle(40);
    chk("bp_count", covered_count, 30);
    chk("bp_model", covered_count, mdl_cnt);
    run_dump(1'b1);

    // reset in the middle of a dump
    dump_req = 1'b1; dump_ready = 1'b1;
    @(negedge clock);
    dump_req = 1'b0;
    idle(5);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clock);
    reset = 1'b0; dump_ready = 1'b0;
    mdl_clear(); mdl_oor = 0;
    idle(2);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
